// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: the generic entry record plus the payload
// layouts each stage packs into pipe_stage's DATA_W bits.
package pipe_pkg;

  localparam int ROB_W_DEF  = 3;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_W_DEF-1:0]  rob;
    logic [DATA_W_DEF-1:0] data;
  } pipe_entry_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        pred_taken;
    logic        bubble;
  } if_id_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [5:0]  opcode;
    logic [20:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [25:0] result;
    logic        wen;
  } ex_wbtl_t;

  typedef struct packed {
    logic [29:0] addr;
    logic        is_load;
    logic        is_store;
  } tl_c_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [25:0] wdata;
    logic        wen;
  } c_wb_t;

  typedef struct packed {
    logic [4:0]  sreg;
    logic [26:0] sval;
  } slreg_t;

endpackage

// File: rtl/pipe_entry.sv
// One valid/rob/data holding register. Load beats clear/kill; data and rob
// keep their last value when the entry is invalidated.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROB_W  = ROB_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              kill,
  input  logic [DATA_W-1:0] d_data,
  input  logic [ROB_W-1:0]  d_rob,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ROB_W-1:0]  rob
);

  // Entry register: reset clears everything, load fills, clear/kill drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      rob   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      rob   <= d_rob;
    end else if (clear || kill) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer
// and squash. Define PIPE_STAGE_SEL_FLUSH_EN for per-ROB-index squash via
// flush_mask; otherwise flush kills everything in the stage.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int SKID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [ROB_W-1:0]      in_rob,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [ROB_W-1:0]      out_rob,
  input  logic                  flush,
  input  logic [2**ROB_W-1:0]   flush_mask,
  output logic [1:0]            count
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [ROB_W-1:0]  main_rob, skid_rob;
  logic              kill_main, kill_skid, kill_in;
  logic              accept, retire;
  logic              main_live, skid_live, in_live;
  logic              load_main, load_skid;
  logic [DATA_W-1:0] main_d_data;
  logic [ROB_W-1:0]  main_d_rob;

`ifdef PIPE_STAGE_SEL_FLUSH_EN
  assign kill_main = flush & flush_mask[main_rob];
  assign kill_skid = flush & flush_mask[skid_rob];
  assign kill_in   = flush & flush_mask[in_rob];
`else
  assign kill_main = flush;
  assign kill_skid = flush;
  assign kill_in   = flush;
  logic unused_flush_mask;
  assign unused_flush_mask = ^flush_mask;
`endif

  assign out_valid = main_valid & ~kill_main;
  assign out_data  = main_data;
  assign out_rob   = main_rob;
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // Entries still present after this edge, in FIFO order main, skid, input.
  // Accept implies skid is empty, so at most two survive and they compact.
  assign main_live = main_valid & ~kill_main & ~retire;
  assign skid_live = skid_valid & ~kill_skid;
  assign in_live   = accept & ~kill_in;

  assign load_main   = ~main_live & (skid_live | in_live);
  assign load_skid   = main_live & ~skid_live & in_live;
  assign main_d_data = skid_live ? skid_data : in_data;
  assign main_d_rob  = skid_live ? skid_rob  : in_rob;

  pipe_entry #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (load_main),
    .clear  (retire),
    .kill   (kill_main),
    .d_data (main_d_data),
    .d_rob  (main_d_rob),
    .valid  (main_valid),
    .data   (main_data),
    .rob    (main_rob)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      logic skid_nv;

      pipe_entry #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (load_skid),
        .clear  (~main_live),
        .kill   (kill_skid),
        .d_data (in_data),
        .d_rob  (in_rob),
        .valid  (skid_valid),
        .data   (skid_data),
        .rob    (skid_rob)
      );

      assign skid_nv = load_skid | (skid_live & main_live);

      // Registered ready: mirrors the next skid occupancy so out_ready never reaches in_ready.
      always_ff @(posedge clk) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= ~skid_nv;
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_rob   = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign count = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: a SKID=1 instance checked through a
// retire scoreboard plus point checks, and a SKID=0 instance for the
// combinational ready path.
module tb_pipe_stage;

  localparam int DW = 32;
  localparam int RW = 3;

  logic          clk;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data, out_data;
  logic [RW-1:0] in_rob, out_rob;
  logic [7:0]    flush_mask;
  logic [1:0]    count;

  logic          in_valid0, in_ready0, out_valid0, out_ready0, flush0;
  logic [DW-1:0] in_data0, out_data0;
  logic [RW-1:0] in_rob0, out_rob0;
  logic [1:0]    count0;

  int tests = 0;
  int fails = 0;
  logic [RW+DW-1:0] sb[$];

  pipe_stage #(.DATA_W(DW), .ROB_W(RW), .SKID(1)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rob(in_rob),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rob(out_rob),
    .flush(flush), .flush_mask(flush_mask), .count(count)
  );

  pipe_stage #(.DATA_W(DW), .ROB_W(RW), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_rob(in_rob0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_rob(out_rob0),
    .flush(flush0), .flush_mask(flush_mask), .count(count0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_kill(input logic [RW-1:0] r);
`ifdef PIPE_STAGE_SEL_FLUSH_EN
    return flush_mask[r];
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard for the SKID=1 instance: pop on retire, drop squashed, push accepted.
  always @(negedge clk) begin
    logic [RW+DW-1:0] keep[$];
    logic [RW+DW-1:0] head;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        tests++;
        assert (sb.size() > 0) else begin
          fails++;
          $error("FAIL sb_extra_retire: observed rob %0d data %0h expected no retire", out_rob, out_data);
        end
        if (sb.size() > 0) begin
          head = sb.pop_front();
          check("sb_retire", {out_rob, out_data}, head);
        end
      end
      if (flush) begin
        keep.delete();
        foreach (sb[k]) if (!tb_kill(sb[k][RW+DW-1:DW])) keep.push_back(sb[k]);
        sb = keep;
      end
      if (in_valid && in_ready && !(flush && tb_kill(in_rob)))
        sb.push_back({in_rob, in_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; in_rob = '0; flush = 0; flush_mask = '0;
  endtask

  initial begin
    reset = 1; out_ready = 0; idle();
    in_valid0 = 0; in_data0 = '0; in_rob0 = '0; out_ready0 = 0; flush0 = 0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rob", out_rob, 0);
    check("rst_count", count, 0);
    check("rst_count0", count0, 0);
    reset = 0;
    tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Streaming, out_ready high.
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1; in_data = 32'h100 + i; in_rob = i[RW-1:0];
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      if (i > 0) begin
        check("stream_latency", out_data, 32'h100 + i - 1);
        check("stream_count", count, 1);
      end
    end
    tick(); idle();
    @(negedge clk);
    check("stream_last", {out_valid, out_data}, {1'b1, 32'h107});
    tick();
    @(negedge clk);
    check("stream_empty", count, 0);

    // Backpressure: three offers, two accepted.
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1; in_data = 32'hA0 + i; in_rob = i[RW-1:0];
    end
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_count_full", count, 2);
    tick(); idle(); out_ready = 1;
    @(negedge clk);
    check("bp_drain0", out_data, 32'hA0);
    tick();
    @(negedge clk);
    check("bp_drain1", out_data, 32'hA1);
    check("bp_count1", count, 1);
    check("bp_in_ready_back", in_ready, 1);
    tick();
    @(negedge clk);
    check("bp_empty", count, 0);

`ifndef PIPE_STAGE_SEL_FLUSH_EN
    // Full flush with the stage full and an offer pending.
    out_ready = 0;
    tick(); in_valid = 1; in_data = 32'hB0; in_rob = 3;
    tick(); in_data = 32'hB1; in_rob = 4;
    tick(); in_data = 32'hB2; in_rob = 5; flush = 1; out_ready = 1;
    @(negedge clk);
    check("ff_out_valid", out_valid, 0);
    tick(); idle();
    @(negedge clk);
    check("ff_count", count, 0);
    check("ff_out_valid_after", out_valid, 0);
    // One stored entry plus an accept during flush: both squashed.
    out_ready = 0;
    tick(); in_valid = 1; in_data = 32'hB8; in_rob = 6;
    tick(); in_data = 32'hB9; in_rob = 7; flush = 1; out_ready = 1;
    @(negedge clk);
    check("ff_in_ready_ungated", in_ready, 1);
    check("ff_out_valid2", out_valid, 0);
    tick(); idle();
    @(negedge clk);
    check("ff_count2", count, 0);
`else
    // Selective flush kills main (rob 2), skid (rob 5) survives and compacts.
    out_ready = 0;
    tick(); in_valid = 1; in_data = 32'hC2; in_rob = 2;
    tick(); in_data = 32'hC5; in_rob = 5;
    tick(); in_valid = 0; flush = 1; flush_mask = 8'h04;
    @(negedge clk);
    check("sf_out_valid", out_valid, 0);
    tick(); idle();
    @(negedge clk);
    check("sf_survivor", {out_valid, out_rob, out_data}, {1'b1, 3'd5, 32'hC5});
    check("sf_count", count, 1);
    out_ready = 1;
    tick();
    @(negedge clk);
    check("sf_empty", count, 0);
`endif

    // Reset mid-operation alongside flush and an offer.
    out_ready = 0;
    tick(); in_valid = 1; in_data = 32'hD0; in_rob = 6;
    tick(); in_data = 32'hD1; in_rob = 7;
    tick(); in_data = 32'hD2; in_rob = 1; reset = 1; flush = 1; flush_mask = 8'hFF;
    @(negedge clk);
    check("rm_count_before", count, 2);
    tick(); idle(); reset = 0;
    @(negedge clk);
    check("rm_out", {out_valid, out_rob, out_data}, '0);
    check("rm_count", count, 0);
    tick();
    @(negedge clk);
    check("rm_in_ready", in_ready, 1);
    check("rm_count_stays", count, 0);

    // SKID=0: combinational ready with back-to-back transfer.
    tick(); in_valid0 = 1; in_data0 = 32'h1; in_rob0 = 1; out_ready0 = 0;
    @(negedge clk);
    check("s0_ready_empty", in_ready0, 1);
    tick(); in_data0 = 32'h2; in_rob0 = 2;
    @(negedge clk);
    check("s0_ready_blocked", in_ready0, 0);
    out_ready0 = 1;
    #1;
    check("s0_ready_comb", in_ready0, 1);
    check("s0_head", {out_valid0, out_data0}, {1'b1, 32'h1});
    tick(); in_valid0 = 0;
    @(negedge clk);
    check("s0_b2b", {out_valid0, out_rob0, out_data0}, {1'b1, 3'd2, 32'h2});
    check("s0_count", count0, 1);
    tick();
    @(negedge clk);
    check("s0_empty", count0, 0);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
